tap_bram_axil_ctrl: RTL and testbench

AXI4-Lite slave that owns the initiator side of the 11-word coefficient (tap) BRAM port. It converts single-beat AXI-Lite writes into byte-enabled BRAM writes and AXI-Lite reads into BRAM reads. It absorbs the BRAM's one-cycle registered-address read latency. It sits between the host AXI-Lite interconnect and the tap BRAM instance in the FIR subsystem.

---
 rtl/tap_bram_axil_ctrl_pkg.sv | 24 ++
 rtl/tap_bram_axil_ctrl_if.sv | 32 +++
 rtl/tap_bram_axil_ctrl.sv | 127 ++++++++++++
 tb/tb_tap_bram_axil_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tap_bram_axil_ctrl_pkg.sv
// Shared definitions for the tap BRAM AXI-Lite controller.
// Holds the bus widths, the tap window location and the FSM and arbitration types.
package tap_bram_axil_ctrl_pkg;

    localparam int AXIL_ADDR_W = 12;
    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

    localparam logic [AXIL_ADDR_W-1:0] TAP_BASE_ADDR = 12'h020;
    localparam int                     TAP_NUM_WORDS = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_RESP = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RD_DATA = 2'd3
    } state_t;

    typedef enum logic {
        GNT_WRITE = 1'b0,
        GNT_READ  = 1'b1
    } grant_t;

endpackage

// File: rtl/tap_bram_axil_ctrl_if.sv
// AXI4-Lite bus (no resp/prot fields) between the host interconnect and the tap controller.
// Handshake: a beat transfers on a rising edge where valid and ready are both high.
interface tap_bram_axil_ctrl_if;
    import tap_bram_axil_ctrl_pkg::*;

    logic [AXIL_ADDR_W-1:0] awaddr;
    logic                   awvalid;
    logic                   awready;
    logic [AXIL_DATA_W-1:0] wdata;
    logic [AXIL_STRB_W-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;
    logic                   bvalid;
    logic                   bready;
    logic [AXIL_ADDR_W-1:0] araddr;
    logic                   arvalid;
    logic                   arready;
    logic [AXIL_DATA_W-1:0] rdata;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bvalid, arready, rdata, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bvalid, arready, rdata, rvalid
    );

endinterface

// File: rtl/tap_bram_axil_ctrl.sv
// AXI-Lite slave driving the initiator port of the 11-word tap BRAM.
// Writes hit the BRAM in the handshake cycle; reads absorb the BRAM's one-cycle latency.
module tap_bram_axil_ctrl
    import tap_bram_axil_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = AXIL_ADDR_W,
    parameter int                    DATA_WIDTH = AXIL_DATA_W,
    parameter int                    NUM_WORDS  = TAP_NUM_WORDS,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = TAP_BASE_ADDR
) (
    input  logic                    CLK,
    input  logic                    RST,
    tap_bram_axil_ctrl_if.slave     axil,
    output logic [DATA_WIDTH/8-1:0] bram_WE,
    output logic                    bram_EN,
    output logic [DATA_WIDTH-1:0]   bram_Di,
    output logic [ADDR_WIDTH-1:0]   bram_A,
    input  logic [DATA_WIDTH-1:0]   bram_Do,
    output state_t                  dbg_state
);

    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_WORDS * 4);

    function automatic logic [ADDR_WIDTH-1:0] word_offset(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:2], 2'b00} - BASE_ADDR;
    endfunction

    // Addresses below the base wrap to a large offset, so one compare covers both ends.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({addr[ADDR_WIDTH-1:2], 2'b00} >= BASE_ADDR) && (word_offset(addr) < SPAN);
    endfunction

    state_t                  state, state_nxt;
    grant_t                  last_grant;
    logic                    grant_wr, grant_rd;
    logic                    wr_ok, rd_ok, rd_ok_q;
    logic [ADDR_WIDTH-1:0]   wr_off, rd_off, a_q;
    logic [DATA_WIDTH-1:0]   di_q, rdata_q;

    assign wr_off    = word_offset(axil.awaddr);
    assign rd_off    = word_offset(axil.araddr);
    assign wr_ok     = in_range(axil.awaddr);
    assign rd_ok     = in_range(axil.araddr);
    assign dbg_state = state;

    // Grants only in IDLE and never in a reset cycle; ties alternate via last_grant.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == ST_IDLE && !RST) begin
            if (axil.awvalid && axil.wvalid && axil.arvalid) begin
                if (last_grant == GNT_READ) grant_wr = 1'b1;
                else                        grant_rd = 1'b1;
            end else if (axil.awvalid && axil.wvalid) begin
                grant_wr = 1'b1;
            end else if (axil.arvalid) begin
                grant_rd = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_wr)      state_nxt = ST_WR_RESP;
                else if (grant_rd) state_nxt = ST_RD_WAIT;
            end
            ST_WR_RESP: if (axil.bready) state_nxt = ST_IDLE;
            ST_RD_WAIT: state_nxt = ST_RD_DATA;
            ST_RD_DATA: if (axil.rready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        axil.awready = grant_wr;
        axil.wready  = grant_wr;
        axil.arready = grant_rd;
        axil.bvalid  = (state == ST_WR_RESP);
        axil.rvalid  = (state == ST_RD_DATA);
        axil.rdata   = rdata_q;
        bram_EN      = 1'b0;
        bram_WE      = '0;
        bram_A       = a_q;
        bram_Di      = di_q;
        if (grant_wr) begin
            bram_A  = wr_off;
            bram_Di = axil.wdata;
            bram_EN = wr_ok;
            bram_WE = wr_ok ? axil.wstrb : '0;
        end else if (grant_rd) begin
            bram_A  = rd_off;
            bram_EN = rd_ok;
        end else if (state == ST_RD_WAIT && !RST) begin
            // BRAM output is gated by EN, so keep it high while Do is sampled.
            bram_EN = rd_ok_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant <= GNT_READ;
            a_q        <= '0;
            di_q       <= '0;
            rd_ok_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (grant_wr) begin
                last_grant <= GNT_WRITE;
                a_q        <= wr_off;
                di_q       <= axil.wdata;
            end else if (grant_rd) begin
                last_grant <= GNT_READ;
                a_q        <= rd_off;
                rd_ok_q    <= rd_ok;
            end
            if (state == ST_RD_WAIT) rdata_q <= rd_ok_q ? bram_Do : '0;
        end
    end

endmodule

// File: tb/tb_tap_bram_axil_ctrl.sv
// Bench for tap_bram_axil_ctrl: table of single transactions plus hand-written
// arbitration, backpressure and reset sequences, with a behavioural tap BRAM.
module tb_tap_bram_axil_ctrl;
    import tap_bram_axil_ctrl_pkg::*;

    localparam logic [11:0] BASE = 12'h020;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        exp_en;
        logic [31:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  bram_WE;
    logic        bram_EN;
    logic [31:0] bram_Di;
    logic [11:0] bram_A;
    logic [31:0] bram_Do;
    state_t      dbg_state;

    logic [31:0] exp_q[$];
    int          tests  = 0;
    int          failed = 0;
    vec_t        vecs[16];

    tap_bram_axil_ctrl_if axil();

    tap_bram_axil_ctrl dut (
        .CLK       (clk),
        .RST       (rst),
        .axil      (axil),
        .bram_WE   (bram_WE),
        .bram_EN   (bram_EN),
        .bram_Di   (bram_Di),
        .bram_A    (bram_A),
        .bram_Do   (bram_Do),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Tap BRAM: registered address, byte writes, output gated by EN.
    logic [31:0] mem [0:15] = '{default: 32'h0};
    logic [3:0]  mem_a_q = 4'd0;
    always @(posedge clk) begin
        if (bram_EN) begin
            mem_a_q <= bram_A[5:2];
            for (int b = 0; b < 4; b++)
                if (bram_WE[b]) mem[bram_A[5:2]][8*b +: 8] <= bram_Di[8*b +: 8];
        end
    end
    assign bram_Do = bram_EN ? mem[mem_a_q] : 32'hDEAD0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // All driver tasks enter and leave 1 time unit after a rising edge.
    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic exp_en);
        int n = 0;
        axil.awaddr = addr; axil.wdata = data; axil.wstrb = strb;
        axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.bready = 1'b1;
        @(negedge clk);
        while (!axil.awready && n < 10) begin @(negedge clk); n++; end
        check("wr_grant", {31'd0, axil.awready && axil.wready}, 32'd1);
        check("wr_en", {31'd0, bram_EN}, {31'd0, exp_en});
        check("wr_we", {28'd0, bram_WE}, exp_en ? {28'd0, strb} : 32'd0);
        if (exp_en) begin
            check("wr_addr", {20'd0, bram_A}, {20'd0, {addr[11:2], 2'b00} - BASE});
            check("wr_di", bram_Di, data);
        end
        @(posedge clk); #1;
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        @(negedge clk);
        check("wr_bvalid", {31'd0, axil.bvalid}, 32'd1);
        check("wr_resp_en", {31'd0, bram_EN}, 32'd0);
        @(posedge clk); #1;
        axil.bready = 1'b0;
    endtask

    task automatic read_issue(input logic [11:0] addr, input logic exp_en, input logic keep_ar);
        int n = 0;
        axil.araddr = addr; axil.arvalid = 1'b1; axil.rready = 1'b0;
        @(negedge clk);
        while (!axil.arready && n < 10) begin @(negedge clk); n++; end
        check("rd_grant", {31'd0, axil.arready}, 32'd1);
        check("rd_en", {31'd0, bram_EN}, {31'd0, exp_en});
        check("rd_we", {28'd0, bram_WE}, 32'd0);
        if (exp_en) check("rd_addr", {20'd0, bram_A}, {20'd0, {addr[11:2], 2'b00} - BASE});
        @(posedge clk); #1;
        axil.arvalid = keep_ar;
    endtask

    // Entered in the RD_WAIT cycle; pops the scoreboard when the beat is accepted.
    task automatic read_finish(input logic exp_en, input int hold);
        logic [31:0] exp;
        @(negedge clk);
        check("rd_wait_rvalid", {31'd0, axil.rvalid}, 32'd0);
        check("rd_wait_en", {31'd0, bram_EN}, {31'd0, exp_en});
        @(posedge clk); #1;
        @(negedge clk);
        check("rd_latency", {31'd0, axil.rvalid}, 32'd1);
        check("rd_no_wgrant", {31'd0, axil.awready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            check("bp_rvalid", {31'd0, axil.rvalid}, 32'd1);
            check("bp_arready", {31'd0, axil.arready}, 32'd0);
            if (exp_q.size() > 0) check("bp_rdata", axil.rdata, exp_q[0]);
            @(posedge clk); #1;
            @(negedge clk);
        end
        if (exp_q.size() == 0) begin
            check("rd_queue_empty", 32'd1, 32'd0);
            exp = 32'h0;
        end else begin
            exp = exp_q.pop_front();
        end
        check("rd_data", axil.rdata, exp);
        axil.rready = 1'b1;
        @(posedge clk); #1;
        axil.rready = 1'b0; axil.arvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] addr, input logic [31:0] exp, input logic exp_en);
        exp_q.push_back(exp);
        read_issue(addr, exp_en, 1'b0);
        read_finish(exp_en, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 12'h028, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0};
        vecs[1]  = '{1'b0, 12'h028, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 12'h02C, 32'h11223344, 4'hF, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 12'h02C, 32'h000000AA, 4'h1, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, 12'h02C, 32'h0,        4'h0, 1'b1, 32'h112233AA};
        vecs[5]  = '{1'b1, 12'h020, 32'hA5A5A5A5, 4'hF, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 12'h022, 32'h0000CC00, 4'h2, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 12'h023, 32'h0,        4'h0, 1'b1, 32'hA5A5CCA5};
        vecs[8]  = '{1'b1, 12'h048, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 12'h048, 32'h0,        4'h0, 1'b1, 32'hCAFEF00D};
        vecs[10] = '{1'b1, 12'h04C, 32'h12345678, 4'hF, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 12'h010, 32'h0,        4'h0, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 12'h04C, 32'h0,        4'h0, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 12'h01C, 32'h55555555, 4'hF, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 12'h024, 32'h0BADF00D, 4'hF, 1'b1, 32'h0};
        vecs[15] = '{1'b0, 12'h020, 32'h0,        4'h0, 1'b1, 32'hA5A5CCA5};

        axil.awaddr = '0; axil.awvalid = 1'b0; axil.wdata = '0; axil.wstrb = '0;
        axil.wvalid = 1'b0; axil.bready = 1'b0; axil.araddr = '0; axil.arvalid = 1'b0;
        axil.rready = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {29'd0, axil.awready, axil.wready, axil.arready}, 32'd0);
        check("rst_valid", {30'd0, axil.bvalid, axil.rvalid}, 32'd0);
        check("rst_en_we", {27'd0, bram_EN, bram_WE}, 32'd0);
        check("rst_addr", {20'd0, bram_A}, 32'd0);
        check("rst_di", bram_Di, 32'd0);
        check("rst_rdata", axil.rdata, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_en);
            else            axi_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_en);
        end

        // Backpressure: rready low for 5 cycles with a competing arvalid.
        exp_q.push_back(32'hCAFEF00D);
        read_issue(12'h048, 1'b1, 1'b1);
        read_finish(1'b1, 5);

        // Reset while rvalid pending; a write offered during reset must be ignored.
        axil.araddr = 12'h028; axil.arvalid = 1'b1;
        @(posedge clk); #1 axil.arvalid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_rvalid", {31'd0, axil.rvalid}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        axil.awaddr = 12'h028; axil.wdata = 32'hFFFFFFFF; axil.wstrb = 4'hF;
        @(posedge clk); #1;
        axil.awvalid = 1'b1; axil.wvalid = 1'b1;
        @(negedge clk);
        check("rst_rvalid_drop", {31'd0, axil.rvalid}, 32'd0);
        check("rst_state_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("rst_no_wgrant", {31'd0, axil.awready}, 32'd0);
        check("rst_no_en", {31'd0, bram_EN}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        @(negedge clk);
        check("post_rst_rvalid", {31'd0, axil.rvalid}, 32'd0);
        @(posedge clk); #1;
        axi_read(12'h028, 32'hDEADBEEF, 1'b1);

        // Tie after a read grant: write wins, read follows once bvalid is accepted.
        axil.awaddr = 12'h030; axil.wdata = 32'h77665544; axil.wstrb = 4'hF;
        axil.awvalid = 1'b1; axil.wvalid = 1'b1;
        axil.araddr = 12'h024; axil.arvalid = 1'b1;
        @(negedge clk);
        check("tie1_wr_first", {30'd0, axil.awready, axil.arready}, 32'd2);
        @(posedge clk); #1;
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        @(negedge clk);
        check("tie1_bvalid", {31'd0, axil.bvalid}, 32'd1);
        check("tie1_rd_blocked", {31'd0, axil.arready}, 32'd0);
        axil.bready = 1'b1;
        @(posedge clk); #1;
        axil.bready = 1'b0;
        @(negedge clk);
        check("tie1_rd_next", {31'd0, axil.arready}, 32'd1);
        exp_q.push_back(32'h0BADF00D);
        @(posedge clk); #1;
        axil.arvalid = 1'b0;
        read_finish(1'b1, 0);

        // A lone write leaves last_grant at WRITE, so the next tie goes to the read.
        axi_write(12'h034, 32'h13572468, 4'hF, 1'b1);
        axil.awaddr = 12'h038; axil.wdata = 32'h2468ACE0; axil.wstrb = 4'hF;
        axil.awvalid = 1'b1; axil.wvalid = 1'b1;
        axil.araddr = 12'h030; axil.arvalid = 1'b1;
        @(negedge clk);
        check("tie2_rd_first", {30'd0, axil.awready, axil.arready}, 32'd1);
        exp_q.push_back(32'h77665544);
        @(posedge clk); #1;
        axil.arvalid = 1'b0;
        read_finish(1'b1, 0);
        @(negedge clk);
        check("tie2_wr_next", {31'd0, axil.awready}, 32'd1);
        check("tie2_wr_addr", {20'd0, bram_A}, 32'h018);
        @(posedge clk); #1;
        axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.bready = 1'b1;
        @(negedge clk);
        check("tie2_bvalid", {31'd0, axil.bvalid}, 32'd1);
        @(posedge clk); #1;
        axil.bready = 1'b0;
        axi_read(12'h038, 32'h2468ACE0, 1'b1);
        axi_read(12'h034, 32'h13572468, 1'b1);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
